// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file, accessed with a pointer-byte protocol.
// Latency: bus events act 3 clk after the pin changes; wr_strobe fires 1 clk after the 8th SCL rise.
// Backpressure: none; every matched byte is ACKed and SCL is never stretched.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  localparam int        PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_out,
  output logic             sda_out,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, PTR, ACK_DATA, WRITE, READ, MACK} state_t;

  state_t             state, state_n;
  logic               scl_s0, scl_s1, scl_d;
  logic               sda_s0, sda_s1, sda_d;
  logic [3:0]         bit_cnt, bit_cnt_n;
  logic [7:0]         shreg, shreg_n;
  logic [7:0]         rx_byte;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic               rw, rw_n;
  logic               sda_q, sda_n;
  logic               we;
  logic [7:0]         regs [NUM_REGS];

  // Idle bus is high, so the synchronizers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {scl_s0, scl_s1, scl_d} <= 3'b111;
      {sda_s0, sda_s1, sda_d} <= 3'b111;
    end else begin
      {scl_s0, scl_s1, scl_d} <= {scl_in, scl_s0, scl_s1};
      {sda_s0, sda_s1, sda_d} <= {sda_in, sda_s0, sda_s1};
    end
  end

  wire scl_rise  = scl_s1 & ~scl_d;
  wire scl_fall  = ~scl_s1 & scl_d;
  wire start_det = scl_s1 & sda_d & ~sda_s1;
  wire stop_det  = scl_s1 & ~sda_d & sda_s1;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    rw_n      = rw;
    sda_n     = sda_q;
    we        = 1'b0;
    rx_byte   = {shreg[6:0], sda_s1};
    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_n     = 1'b1;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_n     = 1'b1;
    end else begin
      case (state)
        ADDR, PTR, WRITE: begin
          if (scl_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              case (state)
                ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    rw_n    = rx_byte[0];
                    state_n = ACK_ADDR;
                  end else begin
                    state_n = IDLE;
                  end
                end
                PTR: begin
                  ptr_n   = rx_byte[PTR_W-1:0];
                  state_n = ACK_DATA;
                end
                default: begin
                  we      = 1'b1;
                  ptr_n   = ptr + 1'b1;
                  state_n = ACK_DATA;
                end
              endcase
            end
          end
        end
        // sda_q still high on the first fall means the ACK has not been driven yet.
        ACK_ADDR: begin
          if (scl_fall) begin
            if (sda_q) begin
              sda_n = 1'b0;
            end else if (rw) begin
              sda_n     = regs[ptr][7];
              shreg_n   = {regs[ptr][6:0], 1'b0};
              bit_cnt_n = 4'd1;
              state_n   = READ;
            end else begin
              sda_n   = 1'b1;
              state_n = PTR;
            end
          end
        end
        ACK_DATA: begin
          if (scl_fall) begin
            if (sda_q) begin
              sda_n = 1'b0;
            end else begin
              sda_n   = 1'b1;
              state_n = WRITE;
            end
          end
        end
        // bit_cnt counts bits already driven; 0 means the byte still has to be loaded.
        READ: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_n     = regs[ptr][7];
              shreg_n   = {regs[ptr][6:0], 1'b0};
              bit_cnt_n = 4'd1;
            end else if (bit_cnt == 4'd8) begin
              sda_n     = 1'b1;
              bit_cnt_n = '0;
              state_n   = MACK;
            end else begin
              sda_n     = shreg[7];
              shreg_n   = {shreg[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (!sda_s1) begin
              ptr_n     = ptr + 1'b1;
              bit_cnt_n = '0;
              state_n   = READ;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      sda_q     <= 1'b1;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      sda_q     <= sda_n;
      wr_strobe <= we;
      if (we) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[ptr] <= rx_byte;
    end
  end

  assign scl_out = 1'b1;
  assign sda_out = sda_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged master on an open-drain bus,
// with write-strobe and read-data scoreboards.
module tb_i2c_slave_regfile;

  localparam int Q = 10;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_out, sda_out, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  wire scl = scl_m & scl_out;
  wire sda = sda_m & sda_out;

  int checks = 0;
  int errors = 0;

  logic [3:0] obs_a [64];
  logic [7:0] obs_d [64];
  int         obs_n = 0;
  int         rd_idx = 0;
  int         sda_low_cnt = 0;

  wr_t        exp_wr [$];
  logic [7:0] exp_rd [$];

  i2c_slave_regfile dut (
    .clk       (clk),
    .resetn    (resetn),
    .scl_in    (scl),
    .sda_in    (sda),
    .scl_out   (scl_out),
    .sda_out   (sda_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe && obs_n < 64) begin
      obs_a[obs_n] = wr_addr;
      obs_d[obs_n] = wr_data;
      obs_n++;
    end
    if (!sda_out) sda_low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitq(input int n = 1);
    repeat (n * Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; waitq();
    scl_m = 1'b1; waitq();
    sda_m = 1'b0; waitq();
    scl_m = 1'b0; waitq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; waitq();
    scl_m = 1'b1; waitq();
    sda_m = 1'b1; waitq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    waitq();
    scl_m = 1'b1; waitq(2);
    scl_m = 1'b0; waitq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; waitq();
    scl_m = 1'b1; waitq();
    ack = sda;    waitq();
    scl_m = 1'b0; waitq();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    d = '0;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      waitq();
      scl_m = 1'b1; waitq();
      d[i] = sda;   waitq();
      scl_m = 1'b0; waitq();
    end
    send_bit(nack);
    sda_m = 1'b1;
  endtask

  // Sends a byte and requires the slave to ACK (expect_ack=1) or leave SDA high.
  task automatic wb(input string tag, input logic [7:0] b, input logic expect_ack);
    logic ack;
    write_byte(b, ack);
    chk(tag, 32'(ack), 32'(!expect_ack));
  endtask

  task automatic wdata(input string tag, input logic [3:0] a, input logic [7:0] b);
    exp_wr.push_back('{a: a, d: b});
    wb(tag, b, 1'b1);
  endtask

  task automatic rdata(input string tag, input logic [7:0] expected, input logic nack);
    logic [7:0] d, e;
    exp_rd.push_back(expected);
    read_byte(nack, d);
    e = exp_rd.pop_front();
    chk(tag, 32'(d), 32'(e));
  endtask

  task automatic drain_wr(input string tag);
    wr_t e;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_strobe_count"}, 32'(obs_n - rd_idx), 32'(exp_wr.size()));
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (rd_idx < obs_n) begin
        chk({tag, "_wr_addr"}, 32'(obs_a[rd_idx]), 32'(e.a));
        chk({tag, "_wr_data"}, 32'(obs_d[rd_idx]), 32'(e.d));
        rd_idx++;
      end
    end
    rd_idx = obs_n;
  endtask

  initial begin
    int low_before;
    logic [7:0] addr_byte;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_out", 32'(sda_out), 32'd1);
    chk("rst_scl_out", 32'(scl_out), 32'd1);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    resetn = 1'b1;
    waitq();

    // Write burst at pointer 2.
    bus_start();
    wb("wr_addr_ack", 8'hA0, 1'b1);
    wb("wr_ptr_ack", 8'h02, 1'b1);
    wdata("wr_d0_ack", 4'd2, 8'hA5);
    wdata("wr_d1_ack", 4'd3, 8'h3C);
    bus_stop();
    drain_wr("burst");

    // Read back through a repeated START.
    bus_start();
    wb("rd_addr_ack", 8'hA0, 1'b1);
    wb("rd_ptr_ack", 8'h02, 1'b1);
    bus_start();
    wb("rd_addr_r_ack", 8'hA1, 1'b1);
    rdata("rd_byte0", 8'hA5, 1'b0);
    rdata("rd_byte1", 8'h3C, 1'b1);
    chk("rd_nack_release", 32'(sda_out), 32'd1);
    bus_stop();
    drain_wr("read");

    // Wrong address: bus must be left alone.
    low_before = sda_low_cnt;
    bus_start();
    wb("mis_addr_nack", 8'hA2, 1'b0);
    wb("mis_data_nack", 8'h00, 1'b0);
    bus_stop();
    chk("mis_sda_never_low", 32'(sda_low_cnt - low_before), 32'd0);
    drain_wr("mismatch");

    // Pointer wrap, then an aliased pointer with upper bits set.
    bus_start();
    wb("wrap_addr_ack", 8'hA0, 1'b1);
    wb("wrap_ptr_ack", 8'h0F, 1'b1);
    wdata("wrap_d0_ack", 4'hF, 8'h11);
    wdata("wrap_d1_ack", 4'h0, 8'h22);
    bus_stop();
    drain_wr("wrap");
    bus_start();
    wb("alias_addr_ack", 8'hA0, 1'b1);
    wb("alias_ptr_ack", 8'h1F, 1'b1);
    wdata("alias_d_ack", 4'hF, 8'h77);
    bus_stop();
    drain_wr("alias");
    bus_start();
    wb("wrap_rd_addr_ack", 8'hA0, 1'b1);
    wb("wrap_rd_ptr_ack", 8'h0F, 1'b1);
    bus_start();
    wb("wrap_rd_addr_r_ack", 8'hA1, 1'b1);
    rdata("wrap_rd15", 8'h77, 1'b0);
    rdata("wrap_rd0", 8'h22, 1'b1);
    bus_stop();

    // STOP in the middle of a data byte.
    bus_start();
    wb("part_addr_ack", 8'hA0, 1'b1);
    wb("part_ptr_ack", 8'h03, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2 == 0));
    bus_stop();
    drain_wr("partial");
    bus_start();
    wb("part_next_addr_ack", 8'hA0, 1'b1);
    wb("part_next_ptr_ack", 8'h03, 1'b1);
    bus_start();
    wb("part_rd_addr_ack", 8'hA1, 1'b1);
    rdata("part_rd3_unchanged", 8'h3C, 1'b1);
    bus_stop();

    // Reset while the slave is holding the address ACK low.
    bus_start();
    addr_byte = 8'hA0;
    for (int i = 7; i >= 0; i--) send_bit(addr_byte[i]);
    sda_m = 1'b1;
    waitq();
    chk("rst_mid_ack_driven", 32'(sda_out), 32'd0);
    resetn = 1'b0;
    #1;
    chk("rst_mid_sda_release", 32'(sda_out), 32'd1);
    chk("rst_mid_wr_strobe", 32'(wr_strobe), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    scl_m = 1'b1;
    waitq();
    bus_start();
    wb("post_rst_addr_ack", 8'hA0, 1'b1);
    wb("post_rst_ptr_ack", 8'h00, 1'b1);
    bus_start();
    wb("post_rst_addr_r_ack", 8'hA1, 1'b1);
    for (int i = 0; i < 16; i++) rdata($sformatf("post_rst_reg%0d", i), 8'h00, 1'(i == 15));
    bus_stop();
    drain_wr("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Synthesizable I2C target (slave) that sits directly on the bus signals driven and sampled by the verification agent's i2c_if.
- Connects through the same tri-state convention: sda_out/scl_out of 1 releases the line, 0 pulls it low.
- Exposes a byte-wide register file that the master reads and writes using a pointer-byte protocol.
- Serves as the block-level DUT for the I2C agent and as a reusable peripheral.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address the block responds to.
- NUM_REGS, 16, number of 8-bit registers. Must be a power of two, 2..256.
- PTR_W, $clog2(NUM_REGS), register pointer width (localparam, not overridable).

Ports:
- clk  input  1  system clock; must run at least 8x the SCL rate.
- resetn  input  1  asynchronous active-low reset.
- scl_in  input  1  sampled SCL line.
- sda_in  input  1  sampled SDA line.
- scl_out  output  1  SCL drive; held at 1, no clock stretching.
- sda_out  output  1  SDA drive; 0 pulls low, 1 releases.
- wr_strobe  output  1  one-clk pulse when a data byte is committed to the register file.
- wr_addr  output  PTR_W  register index of the committed byte (valid with wr_strobe).
- wr_data  output  8  committed byte (valid with wr_strobe).

Behaviour:
- Reset (async, resetn=0):
  - sda_out=1, scl_out=1, wr_strobe=0, wr_addr=0, wr_data=0.
  - All registers 0, pointer 0, state IDLE.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer, then one more flop for edge detection.
  - Events are seen 3 clk after the pin changes.
- Bus conditions:
  - START = synced SDA fall while synced SCL high.
  - STOP = synced SDA rise while synced SCL high.
  - Sampling: a data bit is sampled on the detected SCL rise.
  - Driving: sda_out changes only on the detected SCL fall.
- Start/stop priority:
  - START in any state (including repeated START) goes to ADDR, clears the bit count and releases sda_out.
  - STOP in any state goes to IDLE and releases sda_out. A partial byte is discarded; the pointer is retained.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first.
    - If bits[7:1]==SLAVE_ADDR: go to ACK_ADDR, latch rw=bit0.
    - Otherwise go to IDLE; the bus is ignored until the next START.
  - ACK_ADDR: drive sda_out=0 on the SCL fall after bit 8; release on the SCL fall after the 9th clock.
    - rw=0: go to PTR.
    - rw=1: load shifter with reg[ptr], go to READ.
  - PTR: shift 8 bits; pointer = byte[PTR_W-1:0] (upper bits ignored). ACK, then go to WRITE.
  - WRITE: shift 8 bits.
    - On the 8th SCL rise, write reg[ptr]=byte.
    - wr_strobe pulses on the following clk, with wr_addr=ptr and wr_data=byte.
    - ptr increments, wrapping mod NUM_REGS.
    - ACK the byte, then continue in WRITE.
  - READ:
    - First bit drives on the SCL fall ending the ACK; subsequent bits on each SCL fall, MSB first.
    - After 8 bits, release SDA and go to MACK.
  - MACK: sample SDA on the 9th SCL rise.
    - 0 (ACK): ptr++ (wrapping), load reg[ptr], go to READ.
    - 1 (NACK): go to IDLE, SDA stays released.
- ACK policy: every byte in PTR and WRITE is ACKed; the block never NACKs a matched write.
- Simultaneous events:
  - START/STOP detected on the same clk as an SCL edge: the condition wins and the bit is not sampled.
  - Register write and read of the same index: the read loads the pre-increment location only after its write completes, so the new value is returned.
- Reset mid-transfer: takes effect immediately, SDA released asynchronously.

Test Plan:
- Write burst: START, 0xA0, 0x02, 0xA5, 0x3C, STOP.
  - Required: four ACKs; reg[2]=0xA5, reg[3]=0x3C.
  - wr_strobe pulses twice, with (2,0xA5) then (3,0x3C).
- Read with repeated START: START, 0xA0, 0x02, rSTART, 0xA1; read 2 bytes, master ACK then NACK, STOP.
  - Required: bytes 0xA5 then 0x3C returned; SDA released after the NACK.
- Address mismatch: START, 0xA2, 0x00, STOP.
  - Required: sda_out stays 1 throughout; no wr_strobe.
- Pointer wrap: pointer 0x0F, write 0x11, 0x22.
  - Required: reg[15]=0x11, reg[0]=0x22.
  - Pointer 0x1F also aliases to reg[15].
- STOP after 4 data bits of a write byte.
  - Required: no wr_strobe and no register change.
  - Next START with 0xA0 is ACKed normally.
- resetn low for 2 clk while slave drives an ACK.
  - Required: sda_out=1 immediately and all registers read back 0.
